// File: rtl/mac_job_arbiter.sv
// Round-robin arbiter/sequencer sharing one MAC control unit among N_REQ requesters.
// Optional WAIT-state timeout abort is compiled in with `define MAC_ARB_TIMEOUT_EN.
module mac_job_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 31
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   req_mode,
    input  logic [8*N_REQ-1:0] req_a,
    input  logic [8*N_REQ-1:0] req_b,
    input  logic [8*N_REQ-1:0] req_c,
    input  logic [8*N_REQ-1:0] req_x,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [16:0]        rsp_data,
    output logic               rsp_err,
    output logic               busy,
    output logic               mac_mode,
    output logic               mac_valid_input,
    output logic               mac_last_input,
    output logic [7:0]         mac_num_a,
    output logic [7:0]         mac_num_b,
    output logic [7:0]         mac_num_c,
    output logic [7:0]         mac_num_x,
    input  logic               mac_valid_output,
    input  logic [16:0]        mac_final_output
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_cfg_check
        $error("mac_job_arbiter: N_REQ must be 2..8 and TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LAUNCH,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state_q;
    logic [PW-1:0]     rr_ptr_q;
    logic [PW-1:0]     rr_ptr_d;
    logic [PW-1:0]     owner_q;
    logic              mode_q;
    logic [7:0]        a_q, b_q, c_q, x_q;
    logic [N_REQ-1:0]  gnt_q;
    logic [N_REQ-1:0]  rsp_valid_q;
    logic [16:0]       rsp_data_q;
    logic              busy_q;
    logic              vin_q;
    logic              last_q;

    // Per-requester operand views of the flattened buses
    logic [7:0] a_arr [N_REQ];
    logic [7:0] b_arr [N_REQ];
    logic [7:0] c_arr [N_REQ];
    logic [7:0] x_arr [N_REQ];

    always_comb begin
        for (int g = 0; g < N_REQ; g++) begin
            a_arr[g] = req_a[8*g +: 8];
            b_arr[g] = req_b[8*g +: 8];
            c_arr[g] = req_c[8*g +: 8];
            x_arr[g] = req_x[8*g +: 8];
        end
    end

    // Search ascends from rr_ptr with wrap; first set request wins.
    logic          win_found;
    logic [PW-1:0] win_idx;
    logic [PW:0]   probe;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        probe     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            probe = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (probe >= (PW+1)'(N_REQ)) begin
                probe = probe - (PW+1)'(N_REQ);
            end
            if (!win_found && req[probe[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = probe[PW-1:0];
            end
        end
    end

    assign rr_ptr_d = (owner_q == PW'(N_REQ-1)) ? '0 : owner_q + PW'(1);

`ifdef MAC_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT+1) : 1;
    logic [CW-1:0] wait_cnt_q;
    logic          rsp_err_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            mode_q      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            x_q         <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            vin_q       <= 1'b0;
            last_q      <= 1'b0;
`ifdef MAC_ARB_TIMEOUT_EN
            wait_cnt_q  <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            // Pulsed outputs default low; data is zero outside the response cycle
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
`ifdef MAC_ARB_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
            unique case (state_q)
                S_IDLE: begin
                    if (win_found) begin
                        state_q <= S_SETUP;
                        owner_q <= win_idx;
                        gnt_q   <= N_REQ'(1) << win_idx;
                        mode_q  <= req_mode[win_idx];
                        a_q     <= a_arr[win_idx];
                        b_q     <= b_arr[win_idx];
                        c_q     <= c_arr[win_idx];
                        x_q     <= x_arr[win_idx];
                        busy_q  <= 1'b1;
                    end
                end
                S_SETUP: begin
                    state_q <= S_LAUNCH;
                    vin_q   <= 1'b1;
                    last_q  <= 1'b1;
                end
                S_LAUNCH: begin
                    state_q <= S_WAIT;
                    vin_q   <= 1'b0;
                    last_q  <= 1'b0;
`ifdef MAC_ARB_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                end
                S_WAIT: begin
                    // A result arriving on the timeout cycle still wins
                    if (mac_valid_output) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= N_REQ'(1) << owner_q;
                        rsp_data_q  <= mac_final_output;
`ifdef MAC_ARB_TIMEOUT_EN
                    end else if (wait_cnt_q == CW'(TIMEOUT)) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= N_REQ'(1) << owner_q;
                        rsp_err_q   <= 1'b1;
                    end else begin
                        wait_cnt_q  <= wait_cnt_q + CW'(1);
`endif
                    end
                end
                S_RESP: begin
                    state_q  <= S_IDLE;
                    busy_q   <= 1'b0;
                    rr_ptr_q <= rr_ptr_d;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt             = gnt_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_data        = rsp_data_q;
    assign busy            = busy_q;
    assign mac_mode        = mode_q;
    assign mac_valid_input = vin_q;
    assign mac_last_input  = last_q;
    assign mac_num_a       = a_q;
    assign mac_num_b       = b_q;
    assign mac_num_c       = c_q;
    assign mac_num_x       = x_q;

`ifdef MAC_ARB_TIMEOUT_EN
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mac_job_arbiter.sv
// Directed bench for mac_job_arbiter: behavioural MAC stub plus grant/response scoreboards.
module tb_mac_job_arbiter;
    localparam int N = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req, req_mode;
    logic [8*N-1:0]   req_a, req_b, req_c, req_x;
    logic [N-1:0]     gnt, rsp_valid;
    logic [16:0]      rsp_data;
    logic             rsp_err, busy;
    logic             mac_mode, mac_valid_input, mac_last_input;
    logic [7:0]       mac_num_a, mac_num_b, mac_num_c, mac_num_x;
    logic             mac_valid_output;
    logic [16:0]      mac_final_output;

    mac_job_arbiter #(.N_REQ(N), .TIMEOUT(31)) dut (
        .clk(clk), .reset(reset), .req(req), .req_mode(req_mode),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_x(req_x),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .mac_mode(mac_mode), .mac_valid_input(mac_valid_input),
        .mac_last_input(mac_last_input), .mac_num_a(mac_num_a), .mac_num_b(mac_num_b),
        .mac_num_c(mac_num_c), .mac_num_x(mac_num_x),
        .mac_valid_output(mac_valid_output), .mac_final_output(mac_final_output)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          owner;
        logic [16:0] data;
        logic        err;
    } rsp_t;

    rsp_t rsp_exp[$];
    int   gnt_exp[$];
    int   errors = 0;
    int   checks = 0;

    // MAC reference: trinomial a*x^2+b*x+c, sum-of-products a*x+b*c
    function automatic logic [16:0] mac_fn(input logic m, input logic [7:0] a, b, c, x);
        int r;
        if (m) r = int'(a)*int'(x)*int'(x) + int'(b)*int'(x) + int'(c);
        else   r = int'(a)*int'(x) + int'(b)*int'(c);
        return r[16:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({gnt, rsp_valid, rsp_data, rsp_err, busy, mac_mode, mac_valid_input,
                    mac_last_input, mac_num_a, mac_num_b, mac_num_c, mac_num_x});
    endfunction

    // ---------------- MAC stub ----------------
    int stub_lat = 4;
    bit stub_never = 0;
    int stub_force = 0;
    int stub_cnt = 0;

    always @(negedge clk) begin
        if (reset) begin
            stub_cnt = 0;
            mac_valid_output = 1'b0;
            mac_final_output = '0;
        end else begin
            mac_valid_output = 1'b0;
            mac_final_output = '0;
            if (stub_force > 0) begin
                stub_force--;
                mac_valid_output = 1'b1;
                mac_final_output = 17'h1abcd;
            end else if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0) begin
                    mac_valid_output = 1'b1;
                    mac_final_output = mac_fn(mac_mode, mac_num_a, mac_num_b, mac_num_c, mac_num_x);
                end
            end
            if (mac_valid_input && !stub_never) stub_cnt = stub_lat;
        end
    end

    // ---------------- monitor ----------------
    int          n_gnt = 0, n_launch = 0, last_gnt = -1, launch_cyc = 0, rsp_cyc = 0;
    bit          spacing_on = 0, waiting = 0;
    logic        prev_mode = 1'b0, prev_vi = 1'b0;
    logic [31:0] snap;

    always @(negedge clk) begin
        if (reset) begin
            prev_mode = 1'b0;
            prev_vi   = 1'b0;
            waiting   = 0;
        end else begin
            if (gnt != '0) begin
                if (gnt_exp.size() == 0) chk("gnt_unexpected", 64'(gnt), 64'(0));
                else begin
                    int o;
                    o = gnt_exp.pop_front();
                    chk("gnt_onehot", 64'(gnt), 64'(1 << o));
                    if (spacing_on && last_gnt >= 0) chk("gnt_spacing", 64'(cyc - last_gnt), 64'(8));
                end
                last_gnt = cyc;
                n_gnt++;
            end
            if (rsp_valid != '0) begin
                rsp_cyc = cyc;
                waiting = 0;
                if (rsp_exp.size() == 0) chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
                else begin
                    rsp_t r;
                    r = rsp_exp.pop_front();
                    chk("rsp_owner", 64'(rsp_valid), 64'(1 << r.owner));
                    chk("rsp_data", 64'(rsp_data), 64'(r.data));
                    chk("rsp_err", 64'(rsp_err), 64'(r.err));
                end
            end else begin
                chk("rsp_idle_zero", 64'({rsp_err, rsp_data}), 64'(0));
            end
            if (mac_valid_input) begin
                chk("launch_last", 64'(mac_last_input), 64'(1));
                chk("launch_single", 64'(prev_vi), 64'(0));
                n_launch++;
                launch_cyc = cyc;
                snap = {mac_num_a, mac_num_b, mac_num_c, mac_num_x};
                waiting = 1;
            end else if (waiting && busy) begin
                chk("wait_ops_stable", 64'({mac_num_a, mac_num_b, mac_num_c, mac_num_x}), 64'(snap));
            end
            if (mac_mode !== prev_mode) chk("mode_change_in_setup", 64'(gnt != '0), 64'(1));
            prev_mode = mac_mode;
            prev_vi   = mac_valid_input;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int i, input logic m, input logic [7:0] a, b, c, x);
        req_mode[i]   = m;
        req_a[8*i +: 8] = a;
        req_b[8*i +: 8] = b;
        req_c[8*i +: 8] = c;
        req_x[8*i +: 8] = x;
    endtask

    task automatic push_job(input int i, input logic m, input logic [7:0] a, b, c, x, input logic err);
        rsp_t r;
        r.owner = i;
        r.data  = err ? 17'd0 : mac_fn(m, a, b, c, x);
        r.err   = err;
        gnt_exp.push_back(i);
        rsp_exp.push_back(r);
    endtask

    task automatic wait_gnts(input int target);
        for (int t = 0; t < 300 && n_gnt < target; t++) @(negedge clk);
        chk("gnt_arrived", 64'(n_gnt >= target), 64'(1));
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 300 && (rsp_exp.size() != 0 || gnt_exp.size() != 0 || busy); t++)
            @(negedge clk);
        chk("job_drained", 64'({rsp_exp.size() != 0, gnt_exp.size() != 0, busy}), 64'(0));
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, l0;
        reset = 1'b1; req = '0; req_mode = '0;
        req_a = '0; req_b = '0; req_c = '0; req_x = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", all_outs(), 64'(0));

        // Contention: all four held, 4-cycle MAC -> 0,1,2,3,0 at 8-cycle spacing
        stub_lat = 4; spacing_on = 1; last_gnt = -1;
        for (int i = 0; i < N; i++) set_req(i, i[0], 8'(i+1), 8'd2, 8'd3, 8'(i+2));
        for (int i = 0; i < N; i++) push_job(i, i[0], 8'(i+1), 8'd2, 8'd3, 8'(i+2), 1'b0);
        push_job(0, 1'b0, 8'd1, 8'd2, 8'd3, 8'd2, 1'b0);
        g0 = n_gnt;
        req = 4'b1111;
        wait_gnts(g0 + 5);
        req = '0;
        wait_idle();
        spacing_on = 0;

        // Single trinomial on requester 1: 2*9+4*3+5 = 35
        stub_lat = 3; l0 = n_launch; g0 = n_gnt;
        set_req(1, 1'b1, 8'd2, 8'd4, 8'd5, 8'd3);
        push_job(1, 1'b1, 8'd2, 8'd4, 8'd5, 8'd3, 1'b0);
        req = 4'b0010;
        wait_gnts(g0 + 1);
        req = '0;
        wait_idle();
        chk("single_one_launch", 64'(n_launch - l0), 64'(1));

        // Pointer wrap: serve 2, then 4'b1001 -> 3 before 0
        stub_lat = 2; g0 = n_gnt;
        set_req(2, 1'b1, 8'd1, 8'd1, 8'd1, 8'd1);
        push_job(2, 1'b1, 8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
        req = 4'b0100;
        wait_gnts(g0 + 1);
        req = '0;
        wait_idle();
        g0 = n_gnt;
        set_req(3, 1'b1, 8'd2, 8'd0, 8'd7, 8'd3);
        set_req(0, 1'b1, 8'd0, 8'd5, 8'd1, 8'd6);
        push_job(3, 1'b1, 8'd2, 8'd0, 8'd7, 8'd3, 1'b0);
        push_job(0, 1'b1, 8'd0, 8'd5, 8'd1, 8'd6, 1'b0);
        req = 4'b1001;
        wait_gnts(g0 + 1);
        req[3] = 1'b0;
        wait_gnts(g0 + 2);
        req[0] = 1'b0;
        wait_idle();

        // Mode switch 1 -> 0 -> 1 with longer WAIT
        stub_lat = 6; g0 = n_gnt;
        set_req(0, 1'b0, 8'd3, 8'd0, 8'd0, 8'd4);
        push_job(0, 1'b0, 8'd3, 8'd0, 8'd0, 8'd4, 1'b0);
        req = 4'b0001;
        wait_gnts(g0 + 1);
        req = '0;
        wait_idle();
        g0 = n_gnt;
        set_req(2, 1'b1, 8'd1, 8'd2, 8'd3, 8'd2);
        push_job(2, 1'b1, 8'd1, 8'd2, 8'd3, 8'd2, 1'b0);
        req = 4'b0100;
        wait_gnts(g0 + 1);
        req = '0;
        wait_idle();

        // Serve requester 1 so the pointer sits at 2 before the reset test
        stub_lat = 2; g0 = n_gnt;
        set_req(1, 1'b0, 8'd9, 8'd2, 8'd3, 8'd5);
        push_job(1, 1'b0, 8'd9, 8'd2, 8'd3, 8'd5, 1'b0);
        req = 4'b0010;
        wait_gnts(g0 + 1);
        req = '0;
        wait_idle();

        // Reset in WAIT: job dropped, pointer back to 0
        stub_lat = 20; g0 = n_gnt;
        set_req(3, 1'b1, 8'd1, 8'd1, 8'd1, 8'd1);
        push_job(3, 1'b1, 8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
        req = 4'b1000;
        wait_gnts(g0 + 1);
        req = '0;
        repeat (6) @(negedge clk);
        chk("midjob_busy", 64'(busy), 64'(1));
        rsp_exp.delete();
        reset = 1'b1;
        @(negedge clk);
        chk("reset_midjob_outputs", all_outs(), 64'(0));
        reset = 1'b0;
        repeat (25) @(negedge clk);
        chk("reset_no_rsp", 64'({busy, rsp_valid}), 64'(0));
        stub_lat = 4; g0 = n_gnt;
        set_req(0, 1'b0, 8'd7, 8'd1, 8'd1, 8'd7);
        set_req(2, 1'b1, 8'd3, 8'd3, 8'd3, 8'd3);
        push_job(0, 1'b0, 8'd7, 8'd1, 8'd1, 8'd7, 1'b0);
        push_job(2, 1'b1, 8'd3, 8'd3, 8'd3, 8'd3, 1'b0);
        req = 4'b0101;
        wait_gnts(g0 + 1);
        req[0] = 1'b0;
        wait_gnts(g0 + 2);
        req[2] = 1'b0;
        wait_idle();

        // Stray MAC result while idle must be ignored
        stub_force = 1;
        repeat (4) @(negedge clk);
        chk("stray_output_ignored", 64'({busy, rsp_valid, gnt}), 64'(0));

`ifdef MAC_ARB_TIMEOUT_EN
        // MAC never answers: abort at WAIT count 31
        stub_never = 1; g0 = n_gnt;
        set_req(1, 1'b1, 8'd5, 8'd5, 8'd5, 8'd5);
        push_job(1, 1'b1, 8'd5, 8'd5, 8'd5, 8'd5, 1'b1);
        req = 4'b0010;
        wait_gnts(g0 + 1);
        req = '0;
        wait_idle();
        chk("timeout_latency", 64'(rsp_cyc - launch_cyc), 64'(33));
        // Result lands exactly on count 31: data wins
        stub_never = 0; stub_lat = 32; g0 = n_gnt;
        push_job(1, 1'b1, 8'd5, 8'd5, 8'd5, 8'd5, 1'b0);
        req = 4'b0010;
        wait_gnts(g0 + 1);
        req = '0;
        wait_idle();
        chk("edge_result_latency", 64'(rsp_cyc - launch_cyc), 64'(33));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
